uart_rx_wb: RTL and testbench

//  User-project UART receiver: the device-side end of the bench UART link on mprj_io[5].
//  - Oversamples the serial line and deframes 8N1 bytes (start, 8 data LSB-first, stop).
//  - Buffers received bytes in a FIFO.
//  - Firmware reads the bytes and status over a Wishbone slave in the user address space.
//  - Raises irq while data is pending.

---
 rtl/uart_rx_wb_if.sv | 22 ++
 rtl/uart_rx_wb.sv | 217 +++++++++++++++++++++
 tb/tb_uart_rx_wb.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_wb_if.sv
// Wishbone slave bundle for the UART receiver: the classic wbs_* signal set.
// The master modport is the firmware/bus side, the slave modport the peripheral side.
interface uart_rx_wb_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/uart_rx_wb.sv
// Oversampling 8N1 UART receiver with a byte FIFO and a Wishbone register window.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx_wb #(
    parameter int          FIFO_AW        = 4,
    parameter logic [15:0] DEFAULT_CLKDIV = 16'd4167
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    uart_rx_wb_if.slave wbs,
    input  logic        rx,
    output logic        irq
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif

    logic              rx_meta_q, rx_s_q, rx_prev_q;
    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       div_q, div_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_bad_q, par_bad_d;
    logic [15:0]       clkdiv_q, clkdiv_d;
    logic [2:0]        flag_q, flag_d, flag_set;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              irq_q, irq_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              pop_pend_q, pop_pend_d;
    logic [7:0]        mem [DEPTH];

    logic              push, pop, set_ovr, set_ferr, set_perr;
    logic              cnt_wrap, empty, full;
    logic              req, wr, status_wr;
    logic [1:0]        reg_sel;
    logic [31:0]       rd_data, status_word;
    logic              unused_bits;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign cnt_wrap = (cnt_q == div_q - 16'd1);

    // Receive FSM: mid-bit sampling is anchored on the start-bit half period.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        push      = 1'b0;
        set_ovr   = 1'b0;
        set_ferr  = 1'b0;
        set_perr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s_q) begin
                    state_d   = ST_START;
                    div_d     = clkdiv_q;
                    cnt_d     = '0;
                    par_bad_d = 1'b0;
                end
            end
            ST_START: begin
                if (cnt_q == (div_q >> 1) - 16'd1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_wrap) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s_q != ^shift_q);
                    state_d   = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_wrap) begin
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                    set_perr = par_bad_q;
                    if (!rx_s_q) begin
                        set_ferr = 1'b1;
                    end else if (!par_bad_q) begin
                        if (full) set_ovr = 1'b1;
                        else      push    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req       = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q;
    assign reg_sel   = wbs.wbs_adr_i[3:2];
    assign wr        = req && wbs.wbs_we_i && wbs.wbs_sel_i[0];
    assign status_wr = wr && (reg_sel == 2'd1);
    assign pop       = ack_q && pop_pend_q;
    assign unused_bits = ^{wbs.wbs_adr_i[31:4], wbs.wbs_adr_i[1:0],
                           wbs.wbs_sel_i[3:1], wbs.wbs_dat_i[31:16]};

    assign status_word = {16'b0, 8'(count_q), 3'b0, flag_q, full, empty};
    assign flag_set    = {set_perr, set_ferr, set_ovr};

    // A set event outranks a same-cycle write-1-to-clear.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sticky
        assign flag_d[gi] = flag_set[gi] |
                            (flag_q[gi] & !(status_wr && wbs.wbs_dat_i[gi + 2]));
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0:    if (!empty) rd_data = {24'b0, mem[rd_ptr_q]};
            2'd1:    rd_data = status_word;
            2'd2:    rd_data = {16'b0, clkdiv_q};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        clkdiv_d = clkdiv_q;
        if (wr && reg_sel == 2'd2)
            clkdiv_d = (wbs.wbs_dat_i[15:0] < 16'd4) ? 16'd4 : wbs.wbs_dat_i[15:0];
        ack_d      = req;
        dat_d      = (req && !wbs.wbs_we_i) ? rd_data : '0;
        pop_pend_d = req && !wbs.wbs_we_i && (reg_sel == 2'd0) && !empty;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        irq_d      = (count_d != '0);
    end

    always_ff @(posedge wb_clk_i) begin
        if (push && !wb_rst_i) mem[wr_ptr_q] <= shift_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            div_q      <= DEFAULT_CLKDIV;
            bit_q      <= '0;
            shift_q    <= '0;
            par_bad_q  <= 1'b0;
            clkdiv_q   <= DEFAULT_CLKDIV;
            flag_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            irq_q      <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            pop_pend_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            rx_prev_q  <= rx_s_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_bad_q  <= par_bad_d;
            clkdiv_q   <= clkdiv_d;
            flag_q     <= flag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            irq_q      <= irq_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            pop_pend_q <= pop_pend_d;
        end
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_uart_rx_wb.sv
// Directed bench for uart_rx_wb: serial frames on rx, register access over Wishbone.
`timescale 1ns/1ps
module tb_uart_rx_wb;
    localparam int BIT = 16;
    localparam logic [31:0] A_RXDATA = 32'h0, A_STATUS = 32'h4, A_CLKDIV = 32'h8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic irq;
    int   checks = 0;
    int   failures = 0;

    uart_rx_wb_if bus();

    uart_rx_wb #(.FIFO_AW(4), .DEFAULT_CLKDIV(16'd4167)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (bus.slave),
        .rx       (rx),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  tx;
        logic [31:0] st_before;
        logic [31:0] data;
        logic [31:0] st_after;
    } vec_t;
    vec_t vecs[6];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_sel_i = 4'hF;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdata;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (bus.wbs_ack_o) begin
                got   = 1'b1;
                rdata = bus.wbs_dat_o;
            end
        end
        tick();
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        if (!got) check("ack_timeout", 32'(got), 32'h1);
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
        logic [31:0] d;
        xfer(1'b0, adr, 32'h0, d);
        check(name, d, exp);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] data);
        logic [31:0] d;
        xfer(1'b1, adr, data, d);
        $display("wr   adr=0x%08h data=0x%08h", adr, data);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(BIT);
`endif
        rx = stop;
        tick(BIT);
        rx = 1'b1;
        tick(2 * BIT);
        $display("tx   byte=0x%02h stop=%0d flip=%0d", b, stop, par_flip);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 32'h0000_0100, 32'h0000_00A5, 32'h0000_0001};
        vecs[1] = '{8'h00, 32'h0000_0100, 32'h0000_0000, 32'h0000_0001};
        vecs[2] = '{8'hFF, 32'h0000_0100, 32'h0000_00FF, 32'h0000_0001};
        vecs[3] = '{8'h5A, 32'h0000_0100, 32'h0000_005A, 32'h0000_0001};
        vecs[4] = '{8'h01, 32'h0000_0100, 32'h0000_0001, 32'h0000_0001};
        vecs[5] = '{8'h80, 32'h0000_0100, 32'h0000_0080, 32'h0000_0001};

        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Reset state
        check("reset_irq", 32'(irq), 32'h0);
        check("reset_ack", 32'(bus.wbs_ack_o), 32'h0);
        check("reset_dat", bus.wbs_dat_o, 32'h0);
        rd(A_STATUS, 32'h0000_0001, "reset_status");
        rd(A_CLKDIV, 32'd4167, "reset_clkdiv");
        wr(A_CLKDIV, 32'd16);
        rd(A_CLKDIV, 32'd16, "clkdiv_16");

        // Glitch shorter than half a bit is rejected
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        tick(40);
        rd(A_STATUS, 32'h0000_0001, "glitch_status");
        check("glitch_irq", 32'(irq), 32'h0);
        wr(A_CLKDIV, 32'd2);
        rd(A_CLKDIV, 32'd4, "clkdiv_min");
        wr(A_CLKDIV, 32'd16);

        // Single bytes: send, check pending, pop, check drained
        for (int v = 0; v < 6; v++) begin
            send_frame(vecs[v].tx, 1'b1, 1'b0);
            check($sformatf("v%0d_irq_set", v), 32'(irq), 32'h1);
            rd(A_STATUS, vecs[v].st_before, $sformatf("v%0d_status", v));
            rd(A_RXDATA, vecs[v].data, $sformatf("v%0d_rxdata", v));
            check($sformatf("v%0d_irq_clr", v), 32'(irq), 32'h0);
            rd(A_STATUS, vecs[v].st_after, $sformatf("v%0d_status_after", v));
        end
        check("dat_idle_zero", bus.wbs_dat_o, 32'h0);
        rd(A_RXDATA, 32'h0, "pop_empty");
        rd(A_STATUS, 32'h0000_0001, "pop_empty_status");

        // Overflow: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, 1'b0);
        rd(A_STATUS, 32'h0000_1006, "full_ovr_status");
        for (int i = 0; i < 16; i++) rd(A_RXDATA, 32'(i), $sformatf("drain_%0d", i));
        rd(A_STATUS, 32'h0000_0005, "drained_ovr_status");
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, 32'h0000_0001, "ovr_cleared");

        // Framing error, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0);
        rd(A_STATUS, 32'h0000_0009, "ferr_status");
        check("ferr_irq", 32'(irq), 32'h0);
        send_frame(8'h3C, 1'b1, 1'b0);
        rd(A_STATUS, 32'h0000_0108, "after_ferr_status");
        rd(A_RXDATA, 32'h0000_003C, "after_ferr_rxdata");
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, 32'h0000_0001, "ferr_cleared");

        // Reset during data bit 4 of a frame whose remaining bits are high
        fork
            send_frame(8'hF0, 1'b1, 1'b0);
            begin
                tick(BIT + 4 * BIT + 8);
                rst = 1'b1;
                tick(3);
                rst = 1'b0;
            end
        join
        rd(A_STATUS, 32'h0000_0001, "midreset_status");
        rd(A_CLKDIV, 32'd4167, "midreset_clkdiv");
        wr(A_CLKDIV, 32'd16);
        send_frame(8'h81, 1'b1, 1'b0);
        rd(A_STATUS, 32'h0000_0100, "midreset_one_byte");
        rd(A_RXDATA, 32'h0000_0081, "midreset_rxdata");
        rd(A_STATUS, 32'h0000_0001, "midreset_empty");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h81, 1'b1, 1'b1);
        rd(A_STATUS, 32'h0000_0011, "perr_status");
        wr(A_STATUS, 32'h10);
        rd(A_STATUS, 32'h0000_0001, "perr_cleared");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
